wb_port_arbiter: RTL

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_port_arbiter
//  Description : Shares the single register-file write port between the
//                pipeline writeback stage and a multi-cycle unit (MDU).
//                MDU results are buffered in a small in-order FIFO.
//                Writeback normally wins arbitration. A FIFO head that has
//                lost STARVE_MAX times is then forced through, and the
//                writeback stage stalls for that cycle.
//                q_hit reports queued destinations so that decode can stall
//                on RAW/WAW hazards against results still in the FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
    parameter int DEPTH      = 2,   // FIFO entries, 2 or 4
    parameter int STARVE_MAX = 4    // losses tolerated before head is forced
) (
    input  logic        clk,
    input  logic        rst_n,
    // pipeline writeback stage
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        wb_stall,
    // multi-cycle unit result channel
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_rd,
    input  logic [31:0] mdu_data,
    output logic        mdu_ready,
    // decode-stage hazard query
    input  logic [4:0]  q_rs1,
    input  logic [4:0]  q_rs2,
    input  logic [4:0]  q_rd,
    output logic        q_hit,
    // register-file write port
    output logic        rf_we,
    output logic [4:0]  rf_a3,
    output logic [31:0] rf_wd3
);

    localparam int PW = (DEPTH > 2) ? 2 : 1;
    localparam int SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

    localparam logic [PW:0]   C_DEPTH      = DEPTH[PW:0];
    localparam logic [PW-1:0] C_LAST_PTR   = PW'(DEPTH - 1);
    localparam logic [SW-1:0] C_STARVE_MAX = STARVE_MAX[SW-1:0];

    // FIFO storage and control state
    logic [4:0]    r_rd_mem   [DEPTH];
    logic [31:0]   r_data_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW:0]   r_count;
    logic [SW-1:0] r_starve;

    logic          w_wb_req;
    logic          w_head_valid;
    logic          w_grant_fifo;
    logic          w_grant_wb;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic [PW-1:0] w_head_nxt;
    logic [PW-1:0] w_tail_nxt;
    logic          w_q_hit;

    // Requests are masked by reset so every output is quiet while rst_n is low.
    assign w_wb_req     = rst_n & wb_we & (wb_rd != 5'd0);
    assign w_head_valid = (r_count != '0);

    // Head wins if writeback is idle or the head has starved long enough.
    assign w_grant_fifo = w_head_valid & (~w_wb_req | (r_starve == C_STARVE_MAX));
    assign w_grant_wb   = w_wb_req & ~w_grant_fifo;

    // Ready depends only on occupancy: a full FIFO never accepts even if it
    // pops this cycle, so no combinational path from the pop to mdu_ready.
    assign mdu_ready = rst_n & (r_count < C_DEPTH);
    assign w_accept  = mdu_valid & mdu_ready;
    // Results targeting x0 are accepted but never stored.
    assign w_push    = w_accept & (mdu_rd != 5'd0);
    assign w_pop     = w_grant_fifo;

    assign w_head_nxt = (r_head == C_LAST_PTR) ? '0 : r_head + 1'b1;
    assign w_tail_nxt = (r_tail == C_LAST_PTR) ? '0 : r_tail + 1'b1;

    assign wb_stall = w_wb_req & w_grant_fifo;

    // Register-file write port mux; zero when nothing is granted.
    always_comb begin
        rf_we  = 1'b0;
        rf_a3  = 5'd0;
        rf_wd3 = 32'd0;
        if (w_grant_fifo) begin
            rf_we  = 1'b1;
            rf_a3  = r_rd_mem[r_head];
            rf_wd3 = r_data_mem[r_head];
        end else if (w_grant_wb) begin
            rf_we  = 1'b1;
            rf_a3  = wb_rd;
            rf_wd3 = wb_data;
        end
    end

    // Hazard lookup: a slot is live when its distance from head is below count.
    always_comb begin
        logic [PW-1:0] v_off;
        w_q_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            v_off = PW'(i) - r_head;
            if ({1'b0, v_off} < r_count) begin
                if (((q_rs1 != 5'd0) && (r_rd_mem[i] == q_rs1)) ||
                    ((q_rs2 != 5'd0) && (r_rd_mem[i] == q_rs2)) ||
                    ((q_rd  != 5'd0) && (r_rd_mem[i] == q_rd))) begin
                    w_q_hit = 1'b1;
                end
            end
        end
    end

    assign q_hit = rst_n & w_q_hit;

    // FIFO payload write; contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rd_mem[r_tail]   <= mdu_rd;
            r_data_mem[r_tail] <= mdu_data;
        end
    end

    // Pointers and occupancy; reset empties the queue so nothing is replayed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= w_tail_nxt;
            end
            if (w_pop) begin
                r_head <= w_head_nxt;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Starvation counter: counts head losses, cleared on pop or when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
        end else if (w_pop || !w_head_valid) begin
            r_starve <= '0;
        end else if (w_grant_wb && (r_starve != C_STARVE_MAX)) begin
            r_starve <= r_starve + 1'b1;
        end
    end

endmodule
`default_nettype wire
